io_input_handshake: RTL and testbench

//  Reader side of the user-input path. A CPU IN instruction raises req. The block then waits for a fresh press of the debounced confirm button.
//  On that press it captures the switch bank, returns it on data_out, and pulses ack.
//  One button press satisfies exactly one IN request. waiting drives the "waiting for input" LED.

---
 rtl/io_input_handshake.sv | 131 +++++++++++++
 tb/tb_io_input_handshake.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_handshake.sv
// IN-instruction input handshake: waits for a fresh confirm press, captures switches, pulses ack (optional INPUT_TIMEOUT_EN forces completion).
// Latency: ack and data_out one cycle after the accepted press; no backpressure, req is a level held until ack.
module io_input_handshake #(
  parameter int          DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              btn_db,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ack,
  output logic              waiting,
  output logic              timed_out
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_REL   = 2'd1;
  localparam logic [1:0] WAIT_PRESS = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              capture;
  logic              tmo_hit;
  logic              tmo_now;
  logic [DATA_W-1:0] sw_meta;
  logic [DATA_W-1:0] sw_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

`ifdef INPUT_TIMEOUT_EN
  logic [31:0] count;

  assign tmo_now = (count == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == IDLE) begin
        count <= '0;
      end else if (state == WAIT_REL || state == WAIT_PRESS) begin
        count <= count + 32'd1;
      end
      if (state == IDLE && req) begin
        timed_out <= 1'b0;
      end else if (tmo_hit) begin
        timed_out <= 1'b1;
      end
    end
  end
`else
  // Timeout length only matters when the counter is built in.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TMO_LAST;
  assign tmo_now        = 1'b0;
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = btn_db ? WAIT_REL : WAIT_PRESS;
        end
      end
      WAIT_REL: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (tmo_now) begin
          state_nxt = DONE;
          tmo_hit   = 1'b1;
        end else if (!btn_db) begin
          state_nxt = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        // Abort beats a press; a press beats the timeout.
        if (!req) begin
          state_nxt = IDLE;
        end else if (btn_db) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else if (tmo_now) begin
          state_nxt = DONE;
          tmo_hit   = 1'b1;
        end
      end
      default: begin
        if (!req && !btn_db) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      data_out <= '0;
      ack      <= 1'b0;
      waiting  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ack     <= capture | tmo_hit;
      waiting <= (state_nxt == WAIT_REL) || (state_nxt == WAIT_PRESS);
      if (capture) begin
        data_out <= sw_sync;
      end else if (tmo_hit) begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_io_input_handshake.sv
// Randomized and directed bench for io_input_handshake against a request/press bookkeeping model.
module tb_io_input_handshake;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        btn_db = 1'b0;
  logic [15:0] sw_in = '0;
  logic [15:0] data_out;
  logic        ack;
  logic        waiting;
  logic        timed_out;

  io_input_handshake #(.DATA_W(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .btn_db(btn_db), .sw_in(sw_in),
    .data_out(data_out), .ack(ack), .waiting(waiting), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ack_seen = 0;
  int cyc = 0;
  int w_cyc = 0;
  int a_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a request is outstanding, may first need the held button released,
  // and once served stays served until both req and button are low.
  logic        pend = 0, mrel = 0, served = 0, fin;
  logic        e_ack = 0, e_wait = 0, e_to = 0;
  logic [15:0] e_data = 0, s1m = 0, s2m = 0, syn;
  int          cnt = 0;
  logic        prev_ack = 0, prev_wait = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        pend = 0; mrel = 0; served = 0; e_ack = 0; e_wait = 0; e_to = 0;
        e_data = 0; s1m = 0; s2m = 0; cnt = 0;
      end else begin
        syn = s2m; s2m = s1m; s1m = sw_in;
        e_ack = 0;
        if (served) begin
          if (!req && !btn_db) served = 0;
        end else if (pend) begin
          if (!req) pend = 0;
          else begin
            fin = 0;
`ifdef INPUT_TIMEOUT_EN
            if (cnt == TMO - 1 && (mrel || !btn_db)) begin
              e_data = 0; e_to = 1; fin = 1;
            end
`endif
            if (!fin) begin
              if (mrel) begin
                if (!btn_db) mrel = 0;
              end else if (btn_db) begin
                e_data = syn; e_to = 0; fin = 1;
              end
            end
            if (fin) begin
              e_ack = 1; pend = 0; served = 1;
            end
            cnt++;
          end
        end else if (req) begin
          pend = 1; mrel = btn_db; e_to = 0; cnt = 0;
        end
        e_wait = pend;
      end
      #1;
      cyc++;
      check("ack", {31'd0, ack}, {31'd0, e_ack});
      check("waiting", {31'd0, waiting}, {31'd0, e_wait});
      check("data_out", {16'd0, data_out}, {16'd0, e_data});
      check("timed_out", {31'd0, timed_out}, {31'd0, e_to});
      if (ack) begin
        check("ack_not_back_to_back", {31'd0, prev_ack}, 32'd0);
        ack_seen++;
        a_cyc = cyc;
      end
      if (waiting && !prev_wait) w_cyc = cyc;
      prev_ack = ack;
      prev_wait = waiting;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  int base;
  logic got;

  initial begin
    step(3);
    reset_n = 1'b1;
    step(2);

    // Reset in the middle of a wait
    req = 1'b1;
    step(3);
    check("wait_before_reset", {31'd0, waiting}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_waiting", {31'd0, waiting}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_data", {16'd0, data_out}, 32'd0);
    check("rst_timed_out", {31'd0, timed_out}, 32'd0);
    step(2);
    reset_n = 1'b1;
    req = 1'b0;
    base = ack_seen;
    step(100);
    check("no_ack_after_reset", ack_seen - base, 0);

    // Basic capture
    sw_in = 16'hA5C3;
    step(4);
    req = 1'b1;
    step(3);
    base = ack_seen;
    btn_db = 1'b1;
    step(1);
    check("basic_ack", {31'd0, ack}, 32'd1);
    check("basic_data", {16'd0, data_out}, 32'h0000_A5C3);
    check("basic_waiting", {31'd0, waiting}, 32'd0);
    step(1);
    check("basic_ack_pulse", {31'd0, ack}, 32'd0);
    req = 1'b0; btn_db = 1'b0;
    step(3);
    check("basic_one_ack", ack_seen - base, 1);

    // Button already held when the request arrives
    btn_db = 1'b1; sw_in = 16'h1234;
    step(3);
    base = ack_seen;
    req = 1'b1;
    step(10);
    check("held_no_ack", ack_seen - base, 0);
    sw_in = 16'h5A5A;
    btn_db = 1'b0;
    step(4);
    btn_db = 1'b1;
    step(1);
    check("held_ack", {31'd0, ack}, 32'd1);
    check("held_data", {16'd0, data_out}, 32'h0000_5A5A);

    // Keep the button down through completion and a re-raised request
    step(3);
    req = 1'b0;
    step(3);
    req = 1'b1;
    step(10);
    check("one_press_per_req", ack_seen - base, 1);
    req = 1'b0; btn_db = 1'b0;
    step(1);
    req = 1'b1; sw_in = 16'h0F0F;
    step(3);
    btn_db = 1'b1;
    step(1);
    check("repress_ack", {31'd0, ack}, 32'd1);
    check("repress_data", {16'd0, data_out}, 32'h0000_0F0F);
    req = 1'b0; btn_db = 1'b0; sw_in = 16'hFFFF;
    step(4);

    // Abort before the press
    base = ack_seen;
    req = 1'b1;
    step(2);
    req = 1'b0;
    step(2);
    btn_db = 1'b1;
    step(3);
    check("abort_no_ack", ack_seen - base, 0);
    check("abort_data_kept", {16'd0, data_out}, 32'h0000_0F0F);
    check("abort_waiting", {31'd0, waiting}, 32'd0);
    btn_db = 1'b0;
    step(2);

`ifdef INPUT_TIMEOUT_EN
    // No press: forced completion TMO cycles after waiting rises
    req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2 * TMO && !got; i++) begin
      step(1);
      if (ack) got = 1'b1;
    end
    check("tmo_seen", {31'd0, got}, 32'd1);
    check("tmo_latency", a_cyc - w_cyc, TMO);
    check("tmo_data", {16'd0, data_out}, 32'd0);
    check("tmo_flag", {31'd0, timed_out}, 32'd1);
    req = 1'b0;
    step(3);
    check("tmo_flag_holds", {31'd0, timed_out}, 32'd1);
    req = 1'b1;
    step(1);
    check("tmo_flag_cleared", {31'd0, timed_out}, 32'd0);
    req = 1'b0;
    step(3);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) req = ~req;
      if ($urandom_range(3) == 0) btn_db = ~btn_db;
      if ($urandom_range(7) == 0) sw_in = 16'($urandom);
      step(1);
    end
    req = 1'b0; btn_db = 1'b0;
    step(5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
